mux_nx1_pipe: RTL and testbench

Parametrised N-channel, P-bit registered multiplexer with a registered selector, a one-deep output register and valid/ready flow control. It replaces fixed 2:1 combinational selection wherever a datapath stage needs to choose among several operand sources without lengthening the critical path. Examples are the linearizer/normalizer operand paths and the float/fixed conversion stages. An optional round-robin auto-advance mode lets the block scan channels without control-FSM involvement.

---
 rtl/mux_nx1_pipe.sv | 128 ++++++++++++
 tb/tb_mux_nx1_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_pipe.sv
// mux_nx1_pipe: N-channel, P-bit registered multiplexer with a registered
// selector, a one-deep output register and valid/ready flow control.
// Optional feature macro: MUXN_RR_EN enables round-robin auto-advance of the
// selector after each accept when auto_en is high. Without the macro, auto_en
// is ignored and the selector changes only by load or reset.

module mux_nx1_pipe #(
  parameter  int P  = 32,
  parameter  int N  = 4,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*P-1:0] D_in,
  input  logic [SW-1:0]  MS,
  input  logic           load,
  input  logic           auto_en,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [P-1:0]   D_out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  sel_q,
  output logic           sel_err
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic         accept;
  logic         ms_ok;
  logic [P-1:0] sel_data;

  assign accept = in_valid && in_ready;
  assign ms_ok  = (32'(MS) < 32'(N));

`ifndef MUXN_RR_EN
  // auto_en has no function without the round-robin feature.
  logic unused_auto_en;
  assign unused_auto_en = auto_en;
`endif

  // Pick the channel addressed by the registered selector.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_q == SW'(k)) begin
        sel_data = D_in[k*P +: P];
      end
    end
  end

  // Output-register occupancy state; reset empties it at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy: fill on accept, drain when consumed with nothing new.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (accept) begin
          state_d = FULL;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Handshake outputs derived from occupancy; in_ready allows streaming.
  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b0;
    out_valid = (state_q == FULL);
    in_ready  = !out_valid || out_ready;
  end

  // Capture the selected channel on every accept; otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      D_out <= '0;
    end else if (accept) begin
      D_out <= sel_data;
    end
  end

  // Selector register: load wins; an accept in the same cycle still used the
  // old value because sel_data is driven from sel_q before this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= '0;
    end else if (load) begin
      if (ms_ok) begin
        sel_q <= MS;
      end
`ifdef MUXN_RR_EN
    end else if (accept && auto_en) begin
      sel_q <= (sel_q == SW'(N - 1)) ? '0 : sel_q + SW'(1);
`endif
    end
  end

  // Sticky flag for an out-of-range selector load, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if (load && !ms_ok) begin
      sel_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Self-checking bench for mux_nx1_pipe: a P=32/N=4 instance for streaming,
// backpressure, load collisions, round-robin and reset, and a P=8/N=5
// instance for out-of-range selector loads.

module tb_mux_nx1_pipe;

  logic         clk = 1'b0;
  logic         rst;

  logic [127:0] d_in;
  logic [1:0]   ms;
  logic         load;
  logic         auto_en;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  d_out;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   sel_q;
  logic         sel_err;

  logic [39:0]  d_in5;
  logic [2:0]   ms5;
  logic         load5;
  logic         in_valid5;
  logic         in_ready5;
  logic [7:0]   d_out5;
  logic         out_valid5;
  logic [2:0]   sel_q5;
  logic         sel_err5;

  int checks = 0;
  int errors = 0;
  int exp_ch;

  always #5 clk = ~clk;

  mux_nx1_pipe #(.P(32), .N(4)) dut (
    .clk(clk), .rst(rst), .D_in(d_in), .MS(ms), .load(load),
    .auto_en(auto_en), .in_valid(in_valid), .in_ready(in_ready),
    .D_out(d_out), .out_valid(out_valid), .out_ready(out_ready),
    .sel_q(sel_q), .sel_err(sel_err)
  );

  mux_nx1_pipe #(.P(8), .N(5)) dut5 (
    .clk(clk), .rst(rst), .D_in(d_in5), .MS(ms5), .load(load5),
    .auto_en(1'b0), .in_valid(in_valid5), .in_ready(in_ready5),
    .D_out(d_out5), .out_valid(out_valid5), .out_ready(1'b1),
    .sel_q(sel_q5), .sel_err(sel_err5)
  );

  // Word w on channel k: A5A5 marker, word index in byte 1, channel in byte 0.
  function automatic logic [31:0] chanWord(input int w, input int k);
    return 32'hA5A5_0000 + 32'((w & 255) << 8) + 32'(k);
  endfunction

  // Count one comparison and report it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive every input of the N=4 instance for the coming clock edge.
  task automatic applyStimulus(input int w, input logic v, input logic ordy,
                               input logic ld, input logic [1:0] m,
                               input logic ae);
    for (int k = 0; k < 4; k++) d_in[k*32 +: 32] = chanWord(w, k);
    in_valid  = v;
    out_ready = ordy;
    load      = ld;
    ms        = m;
    auto_en   = ae;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    for (int k = 0; k < 5; k++) d_in5[k*8 +: 8] = 8'h10 + 8'(k);
    ms5 = 3'd0; load5 = 1'b0; in_valid5 = 1'b0;
    step(); step();

    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_d_out",     d_out,          32'd0);
    checkOutput("rst_sel_q",     32'(sel_q),     32'd0);
    checkOutput("rst_sel_err",   32'(sel_err),   32'd0);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
    rst = 1'b0;
    step();

    // Load channel 2, then stream eight words with no bubbles.
    applyStimulus(0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0);
    step();
    checkOutput("load_sel_q", 32'(sel_q), 32'd2);
    for (int w = 0; w < 8; w++) begin
      applyStimulus(w, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
      step();
      checkOutput("stream_d_out",     d_out,           chanWord(w, 2));
      checkOutput("stream_out_valid", 32'(out_valid),  32'd1);
      checkOutput("stream_in_ready",  32'(in_ready),   32'd1);
    end
    applyStimulus(8, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    step();
    checkOutput("drain_out_valid", 32'(out_valid), 32'd0);
    checkOutput("drain_d_hold",    d_out,          chanWord(7, 2));

    // Backpressure: fill, stall three cycles, then release.
    applyStimulus(20, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    step();
    checkOutput("bp_fill", d_out, chanWord(20, 2));
    for (int c = 0; c < 3; c++) begin
      applyStimulus(21, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
      step();
      checkOutput("bp_in_ready",  32'(in_ready),  32'd0);
      checkOutput("bp_d_stable",  d_out,          chanWord(20, 2));
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
    end
    applyStimulus(21, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    #1;
    checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
    step();
    checkOutput("bp_next_word", d_out,          chanWord(21, 2));
    checkOutput("bp_next_valid", 32'(out_valid), 32'd1);
    applyStimulus(22, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    step();
    checkOutput("bp_empty", 32'(out_valid), 32'd0);

    // Load/accept collision: the word in flight uses the old selector.
    applyStimulus(29, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
    step();
    checkOutput("col_sel_q1", 32'(sel_q), 32'd1);
    applyStimulus(30, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0);
    step();
    checkOutput("col_old_sel", d_out,      chanWord(30, 1));
    checkOutput("col_sel_q3",  32'(sel_q), 32'd3);
    applyStimulus(31, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    step();
    checkOutput("col_new_sel", d_out, chanWord(31, 3));
    applyStimulus(32, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    step();

    // Round-robin stimulus from channel 2.
    applyStimulus(39, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0);
    step();
    checkOutput("rr_start_sel", 32'(sel_q), 32'd2);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(40 + i, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
      step();
`ifdef MUXN_RR_EN
      exp_ch = (2 + i) % 4;
`else
      exp_ch = 2;
`endif
      checkOutput("rr_word", d_out, chanWord(40 + i, exp_ch));
    end
`ifdef MUXN_RR_EN
    checkOutput("rr_end_sel", 32'(sel_q), 32'd0);
`else
    checkOutput("rr_end_sel", 32'(sel_q), 32'd2);
`endif
    applyStimulus(46, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    step();

    // Out-of-range selector loads on the N=5 instance.
    ms5 = 3'd3; load5 = 1'b1;
    step();
    checkOutput("oor_sel_q_3", 32'(sel_q5),   32'd3);
    checkOutput("oor_err_0",   32'(sel_err5), 32'd0);
    ms5 = 3'd6;
    step();
    checkOutput("oor_sel_hold", 32'(sel_q5),   32'd3);
    checkOutput("oor_err_set",  32'(sel_err5), 32'd1);
    ms5 = 3'd4;
    step();
    checkOutput("oor_sel_q_4",  32'(sel_q5),   32'd4);
    checkOutput("oor_err_stay", 32'(sel_err5), 32'd1);
    load5 = 1'b0; in_valid5 = 1'b1;
    step();
    checkOutput("oor_ch4_data", 32'(d_out5), 32'h14);
    in_valid5 = 1'b0;
    step();
    checkOutput("oor_err_still", 32'(sel_err5), 32'd1);

    // Asynchronous reset while holding a word under backpressure.
    applyStimulus(50, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    step();
    checkOutput("mid_full", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_d_out",     d_out,          32'd0);
    checkOutput("arst_sel_q",     32'(sel_q),     32'd0);
    checkOutput("arst_sel_err",   32'(sel_err),   32'd0);
    checkOutput("arst_in_ready",  32'(in_ready),  32'd1);
    checkOutput("arst_err5",      32'(sel_err5),  32'd0);
    checkOutput("arst_sel_q5",    32'(sel_q5),    32'd0);
    step();
    rst = 1'b0;
    applyStimulus(51, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    step();
    checkOutput("post_rst_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
